fwd_fft_cmul_pipe: RTL and testbench

Parametrised, fully pipelined complex multiplier for the forward-FFT butterfly datapath. It rotates a data sample by a twiddle factor, (ar + j·ai)·(br + j·bi), with optional per-sample conjugation of the twiddle. It applies fixed-point round-half-up and saturation, and uses a valid/ready handshake with whole-pipeline stall. It supersedes the single real 16×16 unsigned DSP multiplier in the butterfly stage, adding signed mode, width generality, flow control and saturation monitoring.

---
 rtl/fwd_fft_cmul_pipe.sv | 154 +++++++++++++++
 tb/tb_fwd_fft_cmul_pipe.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/fwd_fft_cmul_pipe.sv
// Five-stage pipelined complex multiplier (a * b or a * conj(b)) for the forward-FFT butterfly,
// with round-half-up, output saturation, saturation event counter and whole-pipeline stall.
module fwd_fft_cmul_pipe #(
    parameter int A_W    = 16,
    parameter int B_W    = 16,
    parameter int OUT_W  = 16,
    parameter int FRAC   = 15,
    parameter int SIGNED = 1,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_conj,
    input  logic [A_W-1:0]   ar,
    input  logic [A_W-1:0]   ai,
    input  logic [B_W-1:0]   br,
    input  logic [B_W-1:0]   bi,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_re,
    output logic [OUT_W-1:0] out_im,
    output logic             out_sat,
    output logic [CNT_W-1:0] sat_cnt,
    input  logic             clr_sat
);
    localparam int FW = A_W + B_W + 2;
    localparam int RW = FW + 1;
    localparam bit SGN = (SIGNED != 0);
    localparam logic signed [RW-1:0] ONE     = 1;
    localparam logic signed [RW-1:0] HALF    = ONE <<< (FRAC - 1);
    localparam logic signed [RW-1:0] SAT_MAX = SGN ? (ONE <<< (OUT_W - 1)) - ONE : (ONE <<< OUT_W) - ONE;
    localparam logic signed [RW-1:0] SAT_MIN = SGN ? -(ONE <<< (OUT_W - 1)) : ONE - ONE;

    // Handshake: a sample enters on in_valid & in_ready and leaves on out_valid & out_ready;
    // in_ready depends only on the output stage, and when it is low every stage holds.
    logic adv;

    logic [4:0]              vld_q, vld_d;
    logic [A_W-1:0]          ar_q, ar_d, ai_q, ai_d;
    logic [B_W-1:0]          br_q, br_d, bi_q, bi_d;
    logic                    conj1_q, conj1_d, conj2_q, conj2_d;
    logic signed [FW-1:0]    p_rr_q, p_rr_d, p_ii_q, p_ii_d, p_ri_q, p_ri_d, p_ir_q, p_ir_d;
    logic signed [FW-1:0]    re_full_q, re_full_d, im_full_q, im_full_d;
    logic signed [RW-1:0]    re_rnd_q, re_rnd_d, im_rnd_q, im_rnd_d;
    logic [OUT_W-1:0]        re_out_q, re_out_d, im_out_q, im_out_d;
    logic                    sat_q, sat_d;
    logic [CNT_W-1:0]        sat_cnt_q, sat_cnt_d;

    logic signed [FW-1:0]    ar_x, ai_x, br_x, bi_x;
    logic signed [RW-1:0]    re_ext, im_ext;
    logic                    re_hi, re_lo, im_hi, im_lo;

    always_comb begin
        adv     = ~vld_q[4] | out_ready;
        vld_d   = {vld_q[3:0], in_valid};

        ar_d    = ar;
        ai_d    = ai;
        br_d    = br;
        bi_d    = bi;
        conj1_d = in_conj;

        // Operands widened to the full sum width so products, negation and sums are all exact.
        ar_x    = {{(FW - A_W){SGN & ar_q[A_W-1]}}, ar_q};
        ai_x    = {{(FW - A_W){SGN & ai_q[A_W-1]}}, ai_q};
        br_x    = {{(FW - B_W){SGN & br_q[B_W-1]}}, br_q};
        bi_x    = {{(FW - B_W){SGN & bi_q[B_W-1]}}, bi_q};
        p_rr_d  = ar_x * br_x;
        p_ii_d  = ai_x * bi_x;
        p_ri_d  = ar_x * bi_x;
        p_ir_d  = ai_x * br_x;
        conj2_d = conj1_q;

        re_full_d = conj2_q ? p_rr_q + p_ii_q : p_rr_q - p_ii_q;
        im_full_d = conj2_q ? p_ir_q - p_ri_q : p_ri_q + p_ir_q;

        re_ext   = {re_full_q[FW-1], re_full_q};
        im_ext   = {im_full_q[FW-1], im_full_q};
        re_rnd_d = (re_ext + HALF) >>> FRAC;
        im_rnd_d = (im_ext + HALF) >>> FRAC;

        re_hi    = re_rnd_q > SAT_MAX;
        re_lo    = re_rnd_q < SAT_MIN;
        im_hi    = im_rnd_q > SAT_MAX;
        im_lo    = im_rnd_q < SAT_MIN;
        re_out_d = re_hi ? SAT_MAX[OUT_W-1:0] : (re_lo ? SAT_MIN[OUT_W-1:0] : re_rnd_q[OUT_W-1:0]);
        im_out_d = im_hi ? SAT_MAX[OUT_W-1:0] : (im_lo ? SAT_MIN[OUT_W-1:0] : im_rnd_q[OUT_W-1:0]);
        sat_d    = re_hi | re_lo | im_hi | im_lo;

        // Clear wins over a coincident saturated transfer; the count sticks at all-ones.
        sat_cnt_d = sat_cnt_q;
        if (clr_sat) begin
            sat_cnt_d = '0;
        end else if (vld_q[4] & out_ready & sat_q & ~&sat_cnt_q) begin
            sat_cnt_d = sat_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vld_q     <= '0;
            ar_q      <= '0;
            ai_q      <= '0;
            br_q      <= '0;
            bi_q      <= '0;
            conj1_q   <= 1'b0;
            conj2_q   <= 1'b0;
            p_rr_q    <= '0;
            p_ii_q    <= '0;
            p_ri_q    <= '0;
            p_ir_q    <= '0;
            re_full_q <= '0;
            im_full_q <= '0;
            re_rnd_q  <= '0;
            im_rnd_q  <= '0;
            re_out_q  <= '0;
            im_out_q  <= '0;
            sat_q     <= 1'b0;
            sat_cnt_q <= '0;
        end else begin
            sat_cnt_q <= sat_cnt_d;
            if (adv) begin
                vld_q     <= vld_d;
                ar_q      <= ar_d;
                ai_q      <= ai_d;
                br_q      <= br_d;
                bi_q      <= bi_d;
                conj1_q   <= conj1_d;
                conj2_q   <= conj2_d;
                p_rr_q    <= p_rr_d;
                p_ii_q    <= p_ii_d;
                p_ri_q    <= p_ri_d;
                p_ir_q    <= p_ir_d;
                re_full_q <= re_full_d;
                im_full_q <= im_full_d;
                re_rnd_q  <= re_rnd_d;
                im_rnd_q  <= im_rnd_d;
                re_out_q  <= re_out_d;
                im_out_q  <= im_out_d;
                sat_q     <= sat_d;
            end
        end
    end

    assign in_ready  = adv;
    assign out_valid = vld_q[4];
    assign out_re    = re_out_q;
    assign out_im    = im_out_q;
    assign out_sat   = sat_q;
    assign sat_cnt   = sat_cnt_q;

endmodule

// File: tb/tb_fwd_fft_cmul_pipe.sv
// Directed bench for fwd_fft_cmul_pipe: hand-computed vectors fed through a driver task,
// an expected-queue scoreboard on the output side, and a single summary line.
module tb_fwd_fft_cmul_pipe;
    localparam int A_W   = 16;
    localparam int B_W   = 16;
    localparam int OUT_W = 16;
    localparam int CNT_W = 16;
    localparam int EW    = 2 * OUT_W + 1;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic             in_conj = 1'b0;
    logic [A_W-1:0]   ar = '0, ai = '0;
    logic [B_W-1:0]   br = '0, bi = '0;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic [OUT_W-1:0] out_re, out_im;
    logic             out_sat;
    logic [CNT_W-1:0] sat_cnt;
    logic             clr_sat = 1'b0;

    logic [EW-1:0]    exp_q[$];
    int               t_q[$];
    int               cyc = 0;
    int               n_checks = 0;
    int               n_fail = 0;
    bit               lat_chk = 1'b1;
    logic [EW-1:0]    mon_e;
    int               mon_t;
    logic [OUT_W-1:0] held_re, held_im;

    logic [15:0] bp_ar[8] = '{16'h0100, 16'h0202, 16'h1000, 16'hF000, 16'h0003, 16'hFFFD, 16'h2468, 16'h7FFF};
    logic [15:0] bp_ai[8] = '{16'h0200, 16'hFE00, 16'h0010, 16'h7FFE, 16'h0000, 16'h0000, 16'h1357, 16'h8000};
    logic [15:0] bp_re[8] = '{16'h0080, 16'h0101, 16'h0800, 16'hF800, 16'h0002, 16'hFFFF, 16'h1234, 16'h4000};
    logic [15:0] bp_im[8] = '{16'h0100, 16'hFF00, 16'h0008, 16'h3FFF, 16'h0000, 16'h0000, 16'h09AC, 16'hC000};

    fwd_fft_cmul_pipe #(
        .A_W(A_W), .B_W(B_W), .OUT_W(OUT_W), .FRAC(15), .SIGNED(1), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_conj(in_conj),
        .ar(ar), .ai(ai), .br(br), .bi(bi),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_re(out_re), .out_im(out_im), .out_sat(out_sat),
        .sat_cnt(sat_cnt), .clr_sat(clr_sat)
    );

    // clock / cycle counter
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Presents one sample (called just after a rising edge) and holds it until accepted.
    task automatic drive_sample(input logic [15:0] a_r, input logic [15:0] a_i,
                                input logic [15:0] b_r, input logic [15:0] b_i, input logic cj,
                                input logic [15:0] e_re, input logic [15:0] e_im, input logic e_sat);
        bit acc;
        acc = 1'b0;
        ar = a_r; ai = a_i; br = b_r; bi = b_i; in_conj = cj; in_valid = 1'b1;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (in_ready) begin
                exp_q.push_back({e_sat, e_re, e_im});
                t_q.push_back(cyc);
                acc = 1'b1;
            end
            @(posedge clk);
            #1;
            if (acc) break;
        end
        if (!acc) check_eq("in_ready_timeout", in_ready, 1);
        in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        for (int k = 0; k < 200; k++) begin
            if (exp_q.size() == 0) break;
            @(posedge clk);
        end
        #1;
        check_eq("drain", exp_q.size(), 0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    // scoreboard: compare each output transfer against the expected queue
    always @(negedge clk) begin
        if (reset && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check_eq("unexpected_out", out_valid, 0);
            end else begin
                mon_e = exp_q.pop_front();
                mon_t = t_q.pop_front();
                check_eq("out_re", out_re, mon_e[2*OUT_W-1:OUT_W]);
                check_eq("out_im", out_im, mon_e[OUT_W-1:0]);
                check_eq("out_sat", out_sat, mon_e[2*OUT_W]);
                if (lat_chk) check_eq("latency", cyc - mon_t, 5);
            end
        end
    end

    initial begin
        #1 reset = 1'b0;
        #1;
        check_eq("rst_out_valid", out_valid, 0);
        check_eq("rst_out_re", out_re, 0);
        check_eq("rst_out_im", out_im, 0);
        check_eq("rst_out_sat", out_sat, 0);
        check_eq("rst_sat_cnt", sat_cnt, 0);
        check_eq("rst_in_ready", in_ready, 1);
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1;

        // rotation, conjugation, mixed twiddle, rounding
        drive_sample(16'h4000, 16'h0000, 16'h4000, 16'h4000, 1'b0, 16'h2000, 16'h2000, 1'b0);
        drive_sample(16'h0000, 16'h4000, 16'h0000, 16'h4000, 1'b0, 16'hE000, 16'h0000, 1'b0);
        drive_sample(16'h0000, 16'h4000, 16'h0000, 16'h4000, 1'b1, 16'h2000, 16'h0000, 1'b0);
        drive_sample(16'h2000, 16'h1000, 16'h4000, 16'hC000, 1'b0, 16'h1800, 16'hF800, 1'b0);
        drive_sample(16'h2000, 16'h1000, 16'h4000, 16'hC000, 1'b1, 16'h0800, 16'h1800, 1'b0);
        drive_sample(16'h0001, 16'h0000, 16'h4000, 16'h0000, 1'b0, 16'h0001, 16'h0000, 1'b0);
        drive_sample(16'hFFFF, 16'h0000, 16'h4000, 16'h0000, 1'b0, 16'h0000, 16'h0000, 1'b0);
        wait_drain();
        check_eq("sat_cnt_none", sat_cnt, 0);

        // saturation and counter
        drive_sample(16'h8000, 16'h0000, 16'h8000, 16'h0000, 1'b0, 16'h7FFF, 16'h0000, 1'b1);
        wait_drain();
        check_eq("sat_cnt_one", sat_cnt, 1);

        fork
            drive_sample(16'h8000, 16'h0000, 16'h8000, 16'h0000, 1'b0, 16'h7FFF, 16'h0000, 1'b1);
            begin : clr_branch
                bit seen;
                seen = 1'b0;
                for (int k = 0; k < 30; k++) begin
                    @(negedge clk);
                    if (out_valid) begin
                        seen = 1'b1;
                        break;
                    end
                end
                check_eq("clr_sync", seen, 1);
                clr_sat = 1'b1;
                @(posedge clk);
                #1 clr_sat = 1'b0;
            end
        join
        wait_drain();
        check_eq("sat_cnt_clr", sat_cnt, 0);

        drive_sample(16'h8000, 16'h8000, 16'h7FFF, 16'h7FFF, 1'b0, 16'h0000, 16'h8000, 1'b1);
        drive_sample(16'h8000, 16'h8000, 16'h8000, 16'h7FFF, 1'b0, 16'h7FFF, 16'h0001, 1'b1);
        wait_drain();
        check_eq("sat_cnt_two", sat_cnt, 2);

        // backpressure: 8-sample stream with a 6-cycle stall in the middle
        lat_chk = 1'b0;
        fork
            for (int k = 0; k < 8; k++)
                drive_sample(bp_ar[k], bp_ai[k], 16'h4000, 16'h0000, 1'b0, bp_re[k], bp_im[k], 1'b0);
            begin : stall_branch
                bit seen;
                seen = 1'b0;
                for (int k = 0; k < 40; k++) begin
                    @(negedge clk);
                    if (out_valid) begin
                        seen = 1'b1;
                        break;
                    end
                end
                check_eq("stall_sync", seen, 1);
                @(posedge clk);
                #1 out_ready = 1'b0;
                @(negedge clk);
                held_re = out_re;
                held_im = out_im;
                for (int k = 0; k < 6; k++) begin
                    if (k > 0) @(negedge clk);
                    check_eq("stall_in_ready", in_ready, 0);
                    check_eq("stall_out_valid", out_valid, 1);
                    check_eq("stall_hold_re", out_re, held_re);
                    check_eq("stall_hold_im", out_im, held_im);
                    @(posedge clk);
                end
                #1 out_ready = 1'b1;
            end
        join
        wait_drain();
        lat_chk = 1'b1;

        // reset with samples in flight
        for (int k = 0; k < 4; k++)
            drive_sample(bp_ar[k], bp_ai[k], 16'h4000, 16'h0000, 1'b0, bp_re[k], bp_im[k], 1'b0);
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (out_valid) break;
        end
        @(posedge clk);
        #2 reset = 1'b0;
        #1;
        check_eq("mid_rst_out_valid", out_valid, 0);
        check_eq("mid_rst_out_re", out_re, 0);
        check_eq("mid_rst_out_sat", out_sat, 0);
        check_eq("mid_rst_sat_cnt", sat_cnt, 0);
        check_eq("mid_rst_in_ready", in_ready, 1);
        exp_q.delete();
        t_q.delete();
        @(posedge clk);
        #2 reset = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            check_eq("no_stale_out", out_valid, 0);
        end
        @(posedge clk);
        #1;
        drive_sample(16'h4000, 16'h0000, 16'h4000, 16'h4000, 1'b0, 16'h2000, 16'h2000, 1'b0);
        wait_drain();
        check_eq("final_in_ready", in_ready, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
